// File: rtl/hack_data_memory.sv
// Hack CPU data memory: RAM, screen buffer with display read port, keyboard FIFO.
// Optional illegal-access capture is enabled by defining HACK_MEM_BOUNDS_CHECK_EN.
module hack_data_memory #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int RAM_DEPTH      = 16384,
  parameter int SCREEN_DEPTH   = 8192,
  parameter int KBD_FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_in,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic [DATA_WIDTH-1:0]    data_out,
  input  logic                     kbd_valid_in,
  input  logic [DATA_WIDTH-1:0]    kbd_data_in,
  output logic                     kbd_ready_out,
  input  logic [12:0]              scr_addr_in,
  output logic [DATA_WIDTH-1:0]    scr_data_out,
  output logic                     err_out,
  output logic [ADDRESS_WIDTH-1:0] err_addr_out
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int SCR_AW = $clog2(SCREEN_DEPTH);
  localparam int PW     = $clog2(KBD_FIFO_DEPTH);
  localparam int CW     = $clog2(KBD_FIFO_DEPTH + 1);

  localparam logic [ADDRESS_WIDTH-1:0] RAM_END  = ADDRESS_WIDTH'(RAM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] SCR_BASE = ADDRESS_WIDTH'(32'h4000);
  localparam logic [ADDRESS_WIDTH-1:0] SCR_END  = ADDRESS_WIDTH'(32'h4000 + SCREEN_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] KBD_ADDR = ADDRESS_WIDTH'(32'h6000);
  localparam logic [CW-1:0]            FULL_CNT = CW'(KBD_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] ram_mem    [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] screen_mem [SCREEN_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem   [KBD_FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] scr_q, scr_d;
  logic                  is_ram, is_scr, is_kbd, fifo_full, fifo_empty, push, pop;

  assign is_ram = address_in < RAM_END;
  assign is_scr = (address_in >= SCR_BASE) && (address_in < SCR_END);
  assign is_kbd = address_in == KBD_ADDR;

  assign fifo_full     = count_q == FULL_CNT;
  assign fifo_empty    = count_q == '0;
  // Ready is forced low during reset; a pop never frees space for a same-cycle push.
  assign kbd_ready_out = rst && !fifo_full;
  assign push          = kbd_valid_in && kbd_ready_out;
  assign pop           = write_in && is_kbd && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage arrays carry no reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && write_in && is_ram) ram_mem[address_in[RAM_AW-1:0]] <= data_in;
    if (rst && write_in && is_scr) screen_mem[address_in[SCR_AW-1:0]] <= data_in;
    if (push) fifo_mem[wr_ptr_q] <= kbd_data_in;
  end

  // Display port reads the pre-write contents when the CPU hits the same word.
  assign scr_d = screen_mem[scr_addr_in[SCR_AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) scr_q <= '0;
    else      scr_q <= scr_d;
  end

  assign scr_data_out = scr_q;

  always_comb begin
    data_out = '0;
    if (is_ram)                    data_out = ram_mem[address_in[RAM_AW-1:0]];
    else if (is_scr)               data_out = screen_mem[address_in[SCR_AW-1:0]];
    else if (is_kbd && !fifo_empty) data_out = fifo_mem[rd_ptr_q];
  end

`ifdef HACK_MEM_BOUNDS_CHECK_EN
  localparam logic [ADDRESS_WIDTH-1:0] KBD_END = ADDRESS_WIDTH'(32'h8000);

  logic                     err_q, err_d, err_hit, is_illegal, kbd_region;
  logic [ADDRESS_WIDTH-1:0] err_addr_q, err_addr_d;

  assign is_illegal = !(is_ram || is_scr || is_kbd);
  assign kbd_region = (address_in > KBD_ADDR) && (address_in < KBD_END);
  assign err_hit    = (write_in && is_illegal) || (!write_in && kbd_region);

  // Only the first offending address is kept.
  always_comb begin
    err_d      = err_q | err_hit;
    err_addr_d = (err_hit && !err_q) ? address_in : err_addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_out      = err_q;
  assign err_addr_out = err_addr_q;
`else
  assign err_out      = 1'b0;
  assign err_addr_out = '0;
`endif

endmodule
